// File: rtl/note_pkg.sv
// note_pkg: types and defaults shared by the note voices and the note mixer.
package note_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      OUT  = 2'd2
   } mix_state_e;

   localparam int NOTE_SAMPLE_W   = 8;
   localparam int NOTE_SAMPLE_DIV = 256;

   // Mixed-word width: wide enough that NUM_VOICES all-ones samples never wrap.
   function automatic int out_width(input int sample_w, input int num_voices);
      return sample_w + $clog2(num_voices);
   endfunction

endpackage

// File: rtl/note_pwm.sv
// note_pwm: free-running PWM counter; the compare level is only reloaded when the
// counter wraps, so each PWM period is generated from a single stable level.
module note_pwm #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] level,
   output logic         pwm_out
);

   logic [W-1:0] cnt_q, cnt_d;
   logic [W-1:0] cmp_q, cmp_d;

   always_comb begin
      cnt_d = cnt_q + W'(1);
      cmp_d = (cnt_q == '1) ? level : cmp_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         cmp_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         cmp_q <= cmp_d;
      end
   end

   assign pwm_out = (cnt_q < cmp_q);

endmodule

// File: rtl/note_mixer.sv
// note_mixer: once per sample period, scans the note voices, acks each sample taken
// and publishes the unsigned sum. NOTE_MIXER_PWM_EN adds a PWM rendering of the mix.
module note_mixer
   import note_pkg::*;
#(
   parameter int NUM_VOICES = 4,
   parameter int SAMPLE_W   = NOTE_SAMPLE_W,
   parameter int SAMPLE_DIV = NOTE_SAMPLE_DIV,
   parameter int WAIT_MAX   = 16
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic [NUM_VOICES-1:0]                     voice_enable,
   input  logic [NUM_VOICES-1:0]                     voice_valid,
   input  logic [NUM_VOICES*SAMPLE_W-1:0]            voice_sample,
   output logic [NUM_VOICES-1:0]                     agg_ack,
   output logic [out_width(SAMPLE_W, NUM_VOICES)-1:0] mix_out,
   output logic                                      mix_valid,
   output logic                                      overrun,
   output logic                                      pwm_out
);

   localparam int OUT_W  = out_width(SAMPLE_W, NUM_VOICES);
   localparam int PTR_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam int WAIT_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
   localparam int TICK_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

   mix_state_e          state_q, state_d;
   logic [PTR_W-1:0]    ptr_q, ptr_d;
   logic [OUT_W-1:0]    acc_q, acc_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic                phase_q, phase_d;
   logic [NUM_VOICES-1:0] ack_q, ack_d;
   logic [OUT_W-1:0]    mix_q, mix_d;
   logic                mix_valid_q, mix_valid_d;
   logic                overrun_q, overrun_d;
   logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;

   logic [SAMPLE_W-1:0] sample_arr [NUM_VOICES];

   for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_unpack
      assign sample_arr[gi] = voice_sample[gi*SAMPLE_W +: SAMPLE_W];
   end

   logic tick, last, cur_en, cur_valid, scan_step;
   logic [SAMPLE_W-1:0] cur_sample;

   assign tick       = (tick_cnt_q == TICK_W'(SAMPLE_DIV - 1));
   assign last       = (ptr_q == PTR_W'(NUM_VOICES - 1));
   assign cur_en     = voice_enable[ptr_q];
   assign cur_valid  = voice_valid[ptr_q];
   assign cur_sample = sample_arr[ptr_q];
   // A voice is finished either after its ack/timeout cycle or immediately if disabled.
   assign scan_step  = phase_q | ~cur_en;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         acc_q       <= '0;
         wait_q      <= '0;
         phase_q     <= 1'b0;
         ack_q       <= '0;
         mix_q       <= '0;
         mix_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
         tick_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         acc_q       <= acc_d;
         wait_q      <= wait_d;
         phase_q     <= phase_d;
         ack_q       <= ack_d;
         mix_q       <= mix_d;
         mix_valid_q <= mix_valid_d;
         overrun_q   <= overrun_d;
         tick_cnt_q  <= tick_cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (tick) state_d = SCAN;
         SCAN:    if (scan_step && last) state_d = OUT;
         OUT:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ptr_d       = ptr_q;
      acc_d       = acc_q;
      wait_d      = wait_q;
      phase_d     = phase_q;
      ack_d       = '0;
      mix_d       = mix_q;
      mix_valid_d = 1'b0;
      tick_cnt_d  = tick ? '0 : tick_cnt_q + TICK_W'(1);
      overrun_d   = overrun_q | (tick & (state_q != IDLE));
      case (state_q)
         IDLE: begin
            if (tick) begin
               acc_d   = '0;
               ptr_d   = '0;
               wait_d  = '0;
               phase_d = 1'b0;
            end
         end
         SCAN: begin
            if (scan_step) begin
               wait_d  = '0;
               phase_d = 1'b0;
               if (!last) ptr_d = ptr_q + PTR_W'(1);
            end else if (cur_valid) begin
               acc_d   = acc_q + OUT_W'(cur_sample);
               ack_d   = NUM_VOICES'(1) << ptr_q;
               phase_d = 1'b1;
            end else if (wait_q == WAIT_W'(WAIT_MAX)) begin
               // Timed out: spend one more cycle as the voice's slot, contributing 0.
               phase_d = 1'b1;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         OUT: begin
            mix_d       = acc_q;
            mix_valid_d = 1'b1;
         end
         default: ;
      endcase
   end

   assign agg_ack   = ack_q;
   assign mix_out   = mix_q;
   assign mix_valid = mix_valid_q;
   assign overrun   = overrun_q;

`ifdef NOTE_MIXER_PWM_EN
   note_pwm #(.W(OUT_W)) u_pwm (
      .clk     (clk),
      .rst     (rst),
      .level   (mix_q),
      .pwm_out (pwm_out)
   );
`else
   assign pwm_out = 1'b0;
`endif

endmodule

// File: doc/note_mixer.md
Name: note_mixer

Overview:
- Consumer end of the note-voice sample handshake. Collects one sample per output period from up to NUM_VOICES note voices, acknowledges each voice, and sums the samples into one mixed output word for the audio output stage.
- Sits between the bank of note voices and the DAC/PWM output.
- Sole owner of each voice's ack line.

Parameters:
- NUM_VOICES, 4, number of voice inputs (1..16)
- SAMPLE_W, 8, unsigned sample width per voice
- SAMPLE_DIV, 256, clk cycles per output sample period (>= NUM_VOICES*(WAIT_MAX+2)+2)
- WAIT_MAX, 16, cycles the scanner waits on an enabled voice before substituting 0

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- voice_enable  in  NUM_VOICES  per-voice enable; disabled voices are skipped
- voice_valid  in  NUM_VOICES  voice i holds a sample ready
- voice_sample  in  NUM_VOICES*SAMPLE_W  voice i sample at bits [i*SAMPLE_W +: SAMPLE_W]
- agg_ack  out  NUM_VOICES  one-cycle ack pulse to voice i
- mix_out  out  OUT_W  mixed sample; OUT_W = SAMPLE_W+clog2(NUM_VOICES)
- mix_valid  out  1  one-cycle pulse when mix_out updates
- overrun  out  1  sticky: a period tick arrived while a scan was still in progress
- pwm_out  out  1  PWM of mix_out (see Optional Feature)

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset state: agg_ack=0, mix_out=0, mix_valid=0, overrun=0, pwm_out=0, FSM=IDLE, voice pointer=0, accumulator=0, tick counter=0.
- Tick counter counts 0..SAMPLE_DIV-1 and wraps. Tick = the cycle the count equals SAMPLE_DIV-1.
- FSM states:
  - IDLE: on tick, clear the accumulator, set pointer=0, go to SCAN.
  - SCAN, pointer p:
    - voice_enable[p]=0: skip to p+1 in 1 cycle.
    - voice_enable[p]=1 and voice_valid[p]=1: add voice_sample[p] to the accumulator. Drive agg_ack[p]=1 on the next cycle, for exactly 1 cycle. Then advance.
    - voice_enable[p]=1 and voice_valid[p]=0: count wait cycles. After WAIT_MAX cycles add 0, issue no ack, advance.
    - p = NUM_VOICES-1 completing: go to OUT.
  - OUT: mix_out <= accumulator, mix_valid=1 for 1 cycle, go to IDLE.
- Latency: tick-to-mix_valid is 2 + sum of per-voice scan cycles. With all voices enabled and valid, that is 2 + NUM_VOICES*2 (the ack cycle counts as a scan cycle).
- Arithmetic: unsigned sum with no saturation. OUT_W is sized so the all-ones case fits exactly: 4 x 255 = 1020 within 10 bits.
- At most one agg_ack bit is high in any cycle.
- voice_valid is sampled only while the pointer addresses that voice. A valid that drops before it is addressed is treated as not valid.
- Tick while not in IDLE: the tick is dropped, the scan continues, and overrun is set to 1 until rst.
- All voices disabled: scan takes NUM_VOICES cycles, then mix_out=0 with mix_valid pulsed.
- voice_enable changing mid-scan: only the value at the cycle the voice is addressed matters.
- rst mid-scan: return to the reset state next cycle. Any pending agg_ack is cancelled.

Optional Feature:
- Macro: NOTE_MIXER_PWM_EN.
- Defined: pwm_out = (pwm_cnt < mix_out).
  - pwm_cnt is a free-running OUT_W-bit counter, reset to 0.
  - mix_out is latched into the compare register only when pwm_cnt wraps to 0, so there are no mid-period glitches.
- Not defined: pwm_out is tied to 0, and no counter or compare register is instantiated.

Decomposition:
- Shared package note_pkg holds:
  - the FSM state enum (IDLE, SCAN, OUT)
  - default SAMPLE_W
  - the OUT_W derivation function (SAMPLE_W + clog2(NUM_VOICES))
  - the default SAMPLE_DIV shared with the note voices
- One natural sub-module: note_pwm (counter + compare), instantiated only under NOTE_MIXER_PWM_EN.

Test Plan:
- Reset: assert rst for 3 cycles mid-scan -> all outputs 0, FSM IDLE, no agg_ack afterwards until the next tick.
- Four voices enabled, valid, samples 10/20/30/40 -> one ack each, in order 0..3, each 1 cycle. mix_out=100, mix_valid 10 cycles after tick.
- Saturation bound: four voices at 255 -> mix_out=1020, no wrap.
- Timeout: voice 2 enabled but never valid, others 5 -> voice 2 gets no ack, mix_out=15, mix_valid delayed by WAIT_MAX cycles.
- Overrun: SAMPLE_DIV=8 with voices stalled -> overrun=1 after the second tick and stays 1. Scan still completes with mix_valid.
- PWM (macro defined): mix_out=256, OUT_W=10 -> pwm_out high for 256 of 1024 cycles per period. Macro undefined -> pwm_out constant 0.
